uart_tx: RTL and testbench

- Serial UART transmitter; the upstream partner of the UART receiver. It drives that receiver's RX_IN line directly in loopback and system builds.
- Accepts a parallel byte with a valid strobe and serialises it LSB-first as: start bit, 8 data bits, optional parity bit, stop bit.
- Runs on the same oversampled clock as the receiver; each bit is held for exactly `prescale` clock cycles, so TX and RX share one clock and one prescale setting.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_parity_calc.sv | 14 +
 rtl/uart_tx.sv | 111 +++++++++++
 tb/tb_uart_tx.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART FSM states, line levels and parity type codes
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_BIT       = 1'b0;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - request/line bundle between a byte source and the UART transmitter
interface uart_tx_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      TX_OUT;
  logic                      busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - combinational even/odd parity bit over a data word
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - LSB-first UART serialiser: start, data, optional parity, stop
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_t               state;
  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic [BCW-1:0]            bit_cnt;
  logic [DATA_WIDTH-1:0]     shift_reg;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic                      tx_q;
  logic                      busy_q;
  logic                      par_bit;
  logic                      terminal;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (bus.P_DATA),
    .par_typ (bus.PAR_TYP),
    .par_bit (par_bit)
  );

  assign terminal   = (pcnt == presc_q - PRESCALE_WIDTH'(1));
  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      pcnt      <= '0;
      presc_q   <= PRESCALE_WIDTH'(1);
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_q   <= UART_IDLE_LEVEL;
          busy_q <= 1'b0;
          pcnt   <= '0;
          if (bus.Data_Valid) begin
            // Everything the frame needs is captured here; later input changes are ignored.
            shift_reg <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_bit_q <= par_bit;
            presc_q   <= (bus.prescale == '0) ? PRESCALE_WIDTH'(1) : bus.prescale;
            bit_cnt   <= '0;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
            state     <= START;
          end
        end
        default: begin
          pcnt <= terminal ? '0 : pcnt + 1'b1;
          if (terminal) begin
            case (state)
              START: begin
                tx_q  <= shift_reg[0];
                state <= DATA;
              end
              DATA: begin
                if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                  if (par_en_q) begin
                    tx_q  <= par_bit_q;
                    state <= PARITY;
                  end else begin
                    tx_q  <= UART_IDLE_LEVEL;
                    state <= STOP;
                  end
                end else begin
                  // Present the next bit now so TX_OUT stays a pure flop output.
                  shift_reg <= shift_reg >> 1;
                  tx_q      <= shift_reg[1];
                  bit_cnt   <= bit_cnt + 1'b1;
                end
              end
              PARITY: begin
                tx_q  <= UART_IDLE_LEVEL;
                state <= STOP;
              end
              STOP: begin
                tx_q   <= UART_IDLE_LEVEL;
                busy_q <= 1'b0;
                state  <= IDLE;
              end
              default: begin
                tx_q   <= UART_IDLE_LEVEL;
                busy_q <= 1'b0;
                state  <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx against a bit-per-period frame model
module tb_uart_tx;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus_if ();

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         pt;
    int         ps;
    bit         b2b;
  } frame_t;

  frame_t sb[$];
  int     checks      = 0;
  int     errors      = 0;
  int     frames_sent = 0;
  int     frames_done = 0;
  bit     in_frame    = 1'b0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Line level expected idx cycles after the start bit began.
  function automatic bit exp_bit(input frame_t f, input int idx);
    int b;
    b = idx / f.ps;
    if (b == 0) return 1'b0;
    if (b <= 8) return f.d[b-1];
    if (f.pe && b == 9) return f.pt ^ (($countones(f.d) % 2) == 1);
    return 1'b1;
  endfunction

  initial begin : monitor
    frame_t cur;
    int     idx;
    int     len;
    int     bad;
    longint cyc;
    longint last_end;
    idx = 0; len = 0; bad = 0; cyc = 0; last_end = -10;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RST) begin
        in_frame = 1'b0;
        continue;
      end
      if (!in_frame && bus_if.busy === 1'b1) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_frame", 1, 0);
          cur = '{8'h00, 1'b0, 1'b0, 1, 1'b0};
        end else begin
          cur = sb.pop_front();
        end
        if (cur.b2b) check(cyc == last_end + 1, "b2b_gap", int'(cyc - last_end - 1), 0);
        in_frame = 1'b1;
        idx = 0;
        bad = 0;
        len = (10 + int'(cur.pe)) * cur.ps;
      end
      if (in_frame) begin
        if (idx < len) begin
          if (bus_if.TX_OUT !== exp_bit(cur, idx) || bus_if.busy !== 1'b1) bad++;
          idx++;
        end else begin
          check(bad == 0, $sformatf("frame_bits_%02h", cur.d), bad, 0);
          check(bus_if.busy === 1'b0 && bus_if.TX_OUT === 1'b1, "frame_end",
                int'({bus_if.busy, bus_if.TX_OUT}), 1);
          frames_done++;
          last_end = cyc;
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // mode: 0 = Data_Valid low during frame, 1 = random, 2 = held high
  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input int ps_in,
                      input int mode, input bit b2b);
    frame_t f;
    int     ps;
    ps = (ps_in == 0) ? 1 : ps_in;
    f = '{d, pe, pt, ps, b2b};
    sb.push_back(f);
    frames_sent++;
    bus_if.P_DATA     = d;
    bus_if.PAR_EN     = pe;
    bus_if.PAR_TYP    = pt;
    bus_if.prescale   = 6'(ps_in);
    bus_if.Data_Valid = 1'b1;
    idle(1);
    for (int k = 1; k <= (10 + int'(pe)) * ps; k++) begin
      bus_if.P_DATA     = 8'($urandom);
      bus_if.PAR_EN     = 1'($urandom);
      bus_if.PAR_TYP    = 1'($urandom);
      bus_if.prescale   = 6'($urandom);
      bus_if.Data_Valid = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom) : 1'b0;
      idle(1);
    end
    bus_if.Data_Valid = 1'b0;
  endtask

  initial begin : timeout
    #800000;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $finish;
  end

  initial begin : driver
    frame_t f;
    int     gap;
    int     ps;
    bus_if.P_DATA     = 8'h00;
    bus_if.Data_Valid = 1'b0;
    bus_if.PAR_EN     = 1'b0;
    bus_if.PAR_TYP    = 1'b0;
    bus_if.prescale   = 6'd8;
    RST = 1'b0;
    idle(3);
    check(bus_if.TX_OUT === 1'b1, "reset_tx", int'(bus_if.TX_OUT), 1);
    check(bus_if.busy === 1'b0, "reset_busy", int'(bus_if.busy), 0);
    RST = 1'b1;
    idle(1);

    send(8'hAB, 1'b0, 1'b0, 8, 0, 1'b0);
    idle(2);
    send(8'hCD, 1'b1, 1'b0, 16, 1, 1'b0);
    idle(1);
    send(8'hEF, 1'b1, 1'b1, 32, 1, 1'b0);
    idle(3);
    send(8'h55, 1'b0, 1'b0, 4, 2, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 4, 0, 1'b1);
    idle(2);

    // Abort a frame part-way through data bit 3.
    f = '{8'h96, 1'b0, 1'b0, 8, 1'b0};
    sb.push_back(f);
    bus_if.P_DATA     = 8'h96;
    bus_if.PAR_EN     = 1'b0;
    bus_if.prescale   = 6'd8;
    bus_if.Data_Valid = 1'b1;
    idle(1);
    bus_if.Data_Valid = 1'b0;
    idle(35);
    #1 RST = 1'b0;
    #1;
    check(bus_if.TX_OUT === 1'b1, "abort_tx", int'(bus_if.TX_OUT), 1);
    check(bus_if.busy === 1'b0, "abort_busy", int'(bus_if.busy), 0);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    idle(1);
    check(bus_if.TX_OUT === 1'b1 && bus_if.busy === 1'b0, "post_abort_idle",
          int'({bus_if.busy, bus_if.TX_OUT}), 1);

    send(8'hA5, 1'b0, 1'b0, 8, 0, 1'b0);
    idle(1);
    send(8'hFF, 1'b1, 1'b0, 1, 1, 1'b0);
    send(8'h5A, 1'b1, 1'b1, 0, 1, 1'b1);

    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 2);
      idle(gap);
      ps = ($urandom_range(0, 5) == 0) ? 63 : $urandom_range(0, 12);
      send(8'($urandom), 1'($urandom), 1'($urandom), ps, $urandom_range(0, 2), gap == 0);
    end

    for (int t = 0; t < 2000 && (sb.size() != 0 || in_frame); t++) @(posedge CLK);
    idle(2);
    check(sb.size() == 0 && !in_frame, "drain", sb.size(), 0);
    check(frames_done == frames_sent, "frame_count", frames_done, frames_sent);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
